data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage load/store traffic.
- Accepts one request at a time over a valid/ready handshake and models a fixed multi-cycle access latency over an internal word array.
- Returns load data with an error flag.
- Drives a stall output that the hazard unit uses to freeze PC, IF/ID and downstream stage registers while an access is in flight.

Parameters:
- DEPTH_WORDS, 512, number of 32-bit words in the array; must be a power of 2.
- READ_LATENCY, 2, cycles from request acceptance to rsp_valid for loads; minimum 1.
- WRITE_LATENCY, 1, cycles from request acceptance to rsp_valid for stores; minimum 1.

Ports:
- clk  in  1  clock; all state updates on falling edge, same as the pipeline registers
- reset  in  1  synchronous, active-high
- req_valid  in  1  MEM stage presents a request
- req_ready  out  1  responder can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address (alu_out of MEM stage)
- req_wdata  in  32  store data
- req_be  in  4  byte enables, bit i = byte lane i (little-endian)
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  32  load data; valid only while rsp_valid=1 and the request was a load
- rsp_err  out  1  qualifies rsp_valid: misaligned or out-of-range access
- stall  out  1  high from acceptance until the cycle rsp_valid is asserted (inclusive of acceptance, exclusive of rsp_valid)

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0, FSM=IDLE, latency counter=0. Array contents are not cleared.
- Reset asserted mid-access: the access is abandoned, nothing is written, and no rsp_valid is produced.
- Acceptance: when req_valid && req_ready at a falling edge, latch write, word index (req_addr[31:2]), wdata, be. Compute err = (req_addr[1:0]!=0) || (word index >= DEPTH_WORDS).
- FSM states: IDLE, BUSY, RESP.
- IDLE -> BUSY on acceptance. Load counter with latency-1 (READ_LATENCY or WRITE_LATENCY). req_ready=0 and stall=1 while in BUSY.
- BUSY: decrement the counter each cycle; go to RESP when the counter reaches 0.
- Latency-1 case: the acceptance edge goes directly to RESP.
- RESP entry edge (store, err=0): commit the write to the array under be.
- RESP entry edge (load): register rsp_rdata from the array. If err=1, force rsp_rdata=0.
- RESP: rsp_valid=1 for exactly one cycle and stall=0. req_ready=1, so a new request can be accepted in the same cycle; back-to-back accesses therefore cost latency+0 bubbles. Next state is BUSY on a new acceptance, else IDLE.
- A store with err=1 is not written and returns rsp_err=1.
- Latency from acceptance to rsp_valid is READ_LATENCY cycles for loads and WRITE_LATENCY cycles for stores.
- req_valid while req_ready=0 is ignored; the requester must hold the request, and the stall output guarantees it does.
- Load-after-store to the same word: the load observes the stored data because the write commits before the next acceptance.
- Word index is req_addr[31:2]; the upper bits are compared against DEPTH_WORDS with no wrap-around.

Optional Feature:
- Macro: DMEM_BYTE_EN_EN.
- Defined: store writes only the byte lanes with req_be[i]=1. req_be=0 is a legal no-op store and still responds.
- Undefined: req_be is ignored and every error-free store writes the full 32-bit word. Load behaviour is identical in both builds.

Decomposition:
- Shared package dmem_pkg:
  - FSM state encoding (IDLE/BUSY/RESP)
  - WORD_BYTES=4
  - request struct {write, word_idx, wdata, be}
  - function word_index(addr)
- Natural sub-module: dmem_array — the word array with a single read port, a byte-masked write port and a registered read. The FSM and latency counter stay in data_mem_responder.

Test Plan:
- Store then load: store addr 0x10 data 0xDEADBEEF, then load 0x10 -> second rsp_valid carries rsp_rdata=0xDEADBEEF, rsp_err=0. Load rsp_valid comes exactly READ_LATENCY cycles after acceptance; stall is high for the READ_LATENCY-1 cycles before it.
- Byte-enable store (DMEM_BYTE_EN_EN defined): word 0x20=0x11223344, then store 0xAABBCCDD with be=4'b0101 -> load returns 0x11BB33DD. Without the macro -> 0xAABBCCDD.
- Error cases:
  - Load 0x13 -> rsp_err=1, rsp_rdata=0.
  - Store to 4*DEPTH_WORDS -> rsp_err=1, array unchanged (verified by a subsequent readback of word 0).
- Back-to-back: req_valid held high with 3 loads -> exactly 3 rsp_valid pulses, spaced READ_LATENCY cycles apart; no request dropped or duplicated.
- Reset mid-access: assert reset one cycle after accepting a store of 0x55 to 0x40 -> no rsp_valid, req_ready=1 and stall=0 after reset, word 0x40 retains its prior value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, request payload, index helper.
package dmem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned IDX_W      = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                    write;
        logic [IDX_W-1:0]        word_idx;
        logic [DATA_W-1:0]       wdata;
        logic [WORD_BYTES-1:0]   be;
    } dmem_req_t;

    // Word index of a byte address; the low two bits select the byte lane.
    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array: one byte-masked write port and one registered read port, falling-edge clocked.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 512
)(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              rd_en,
    input  logic                              rd_zero,
    input  logic [$clog2(DEPTH_WORDS)-1:0]    rd_idx,
    input  logic                              wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0]    wr_idx,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic [WORD_BYTES-1:0]             wr_be,
    output logic [DATA_W-1:0]                 rd_data
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane masked write; contents are deliberately not reset.
    always_ff @(negedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(WORD_BYTES); b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Registered read; rd_zero returns zero for faulting loads without touching the array.
    always_ff @(negedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder with fixed access latency and hazard stall output.
// Optional macro DMEM_BYTE_EN_EN: stores honour req_be; otherwise full-word stores.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS   = 512,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    input  logic [WORD_BYTES-1:0]   req_be,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    stall
);

    localparam int unsigned ARR_AW  = $clog2(DEPTH_WORDS);
    localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    state_t                 state;
    state_t                 state_nx;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nx;
    dmem_req_t              req_q;
    logic                   err_q;

    dmem_req_t              new_req;
    logic                   new_err;
    logic [CNT_W-1:0]       new_lat;
    logic                   accept;
    logic                   latch;
    logic                   fire;
    logic                   fire_new;
    dmem_req_t              cur_req;
    logic                   cur_err;
    logic                   wr_en;
    logic                   rd_en;
    logic [WORD_BYTES-1:0]  wr_be;

    // Decode the incoming request: payload, fault, and counter preload.
    always_comb begin
        new_req.write    = req_write;
        new_req.word_idx = word_index(req_addr);
        new_req.wdata    = req_wdata;
        new_req.be       = req_be;
        new_err          = (req_addr[1:0] != 2'b00) || (new_req.word_idx >= IDX_W'(DEPTH_WORDS));
        new_lat          = req_write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
        accept           = req_valid && req_ready;
    end

    // Next-state logic; fire marks the edge that enters RESP and commits the access.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        latch    = 1'b0;
        fire     = 1'b0;
        fire_new = 1'b0;
        unique case (state)
            IDLE, RESP: begin
                state_nx = IDLE;
                if (accept) begin
                    latch = 1'b1;
                    if (new_lat == '0) begin
                        state_nx = RESP;
                        fire     = 1'b1;
                        fire_new = 1'b1;
                    end else begin
                        state_nx = BUSY;
                        cnt_nx   = new_lat;
                    end
                end
            end
            BUSY: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = RESP;
                    fire     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Access being committed: the live request on single-cycle accesses, else the latched one.
    always_comb begin
        cur_req = fire_new ? new_req : req_q;
        cur_err = fire_new ? new_err : err_q;
        wr_en   = fire && cur_req.write && !cur_err && !reset;
        rd_en   = fire && !cur_req.write && !reset;
`ifdef DMEM_BYTE_EN_EN
        wr_be   = cur_req.be;
`else
        // All lanes forced on: byte enables have no effect in this build.
        wr_be   = cur_req.be | {WORD_BYTES{1'b1}};
`endif
    end

    // State, counter and handshake/response outputs.
    always_ff @(negedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            stall     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            req_ready <= (state_nx != BUSY);
            stall     <= (state_nx == BUSY);
            rsp_valid <= fire;
            if (fire) begin
                rsp_err <= cur_err;
            end
        end
    end

    // Request latch for multi-cycle accesses.
    always_ff @(negedge clk) begin
        if (reset) begin
            req_q <= '0;
            err_q <= 1'b0;
        end else if (latch) begin
            req_q <= new_req;
            err_q <= new_err;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .rd_zero (cur_err),
        .rd_idx  (ARR_AW'(cur_req.word_idx)),
        .wr_en   (wr_en),
        .wr_idx  (ARR_AW'(cur_req.word_idx)),
        .wr_data (cur_req.wdata),
        .wr_be   (wr_be),
        .rd_data (rsp_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed requests push expectations, a monitor checks responses.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned RL    = 2;
    localparam int unsigned WL    = 3;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    data_mem_responder #(
        .DEPTH_WORDS   (DEPTH),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one request, wait (bounded) for acceptance, push the expected response.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                         input string name, output int acc);
        logic rdy;
        logic accepted;
        exp_t e;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        accepted  = 1'b0;
        acc       = -1;
        for (int i = 0; i < 100 && !accepted; i++) begin
            rdy = req_ready;
            @(negedge clk);
            #1;
            accepted = rdy;
        end
        req_valid = 1'b0;
        if (!accepted) begin
            errors++;
            checks++;
            $display("FAIL %s_accept: request not accepted within 100 cycles", name);
        end else begin
            acc     = cyc;
            e.write = wr;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.lat   = wr ? int'(WL) : int'(RL);
            e.acc   = acc;
            e.name  = name;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d responses outstanding after 100 cycles", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: stall expectation every cycle, response contents and timing on rsp_valid.
    exp_t mon_e;
    logic mon_stall;
    always @(posedge clk) begin
        if (!reset) begin
            mon_stall = (sb.size() != 0) && !rsp_valid;
            check("stall", 32'(stall), 32'(mon_stall));
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_rsp: rsp_valid with nothing outstanding at cycle %0d", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_err"}, 32'(rsp_err), 32'(mon_e.err));
                    if (!mon_e.write) begin
                        check({mon_e.name, "_rdata"}, rsp_rdata, mon_e.rdata);
                    end
                    check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.acc + mon_e.lat - 1));
                end
            end
        end
    end

    logic [31:0] be_exp;
    int a0, a1, a2;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;

        // Store then load of the same word.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "st_10", a0);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, "ld_10", a0);
        drain();

        // Partial-lane store.
`ifdef DMEM_BYTE_EN_EN
        be_exp = 32'h11BB33DD;
`else
        be_exp = 32'hAABBCCDD;
`endif
        issue(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, "st_20_full", a0);
        issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, "st_20_be", a0);
        issue(1'b0, 32'h20, 32'h0, 4'hF, be_exp, 1'b0, "ld_20", a0);
        drain();

        // Misaligned accesses: load faults with zero data, store faults and leaves word 4 intact.
        issue(1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1, "ld_misaligned", a0);
        issue(1'b1, 32'h12, 32'h01020304, 4'hF, 32'h0, 1'b1, "st_misaligned", a0);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, "ld_10_after_bad", a0);
        drain();

        // Out-of-range store aliases word 0 in the low index bits; word 0 must not change.
        issue(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "st_0", a0);
        issue(1'b1, 32'(4 * DEPTH), 32'hBAD0BAD0, 4'hF, 32'h0, 1'b1, "st_oor", a0);
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, "ld_0", a0);
        drain();

        // Last valid word and an out-of-range load at the top of the address space.
        issue(1'b1, 32'(4 * DEPTH - 4), 32'h0BADCAFE, 4'hF, 32'h0, 1'b0, "st_last", a0);
        issue(1'b0, 32'(4 * DEPTH - 4), 32'h0, 4'hF, 32'h0BADCAFE, 1'b0, "ld_last", a0);
        issue(1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, 32'h0, 1'b1, "ld_top", a0);
        drain();

        // Back-to-back loads with req_valid held: acceptances spaced by the read latency.
        issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, "b2b_0", a0);
        issue(1'b0, 32'h20, 32'h0, 4'hF, be_exp, 1'b0, "b2b_1", a1);
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, "b2b_2", a2);
        check("b2b_gap_01", 32'(a1 - a0), 32'(RL));
        check("b2b_gap_12", 32'(a2 - a1), 32'(RL));
        drain();

        // Reset one cycle into a store: abandoned, no response, word keeps its old value.
        issue(1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0, 1'b0, "st_40", a0);
        drain();
        issue(1'b1, 32'h40, 32'h00000055, 4'hF, 32'h0, 1'b0, "st_40_abort", a0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        sb.delete();
        reset = 1'b0;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (6) @(negedge clk);
        #1;
        issue(1'b0, 32'h40, 32'h0, 4'hF, 32'h12345678, 1'b0, "ld_40", a0);
        drain();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
